sys_reg_node: RTL

SYS_REG_NODE -- requirements
Module: sys_reg_node

---
 rtl/sys_reg_node.sv | 114 +++++++++++
 1 files changed

// File: rtl/sys_reg_node.sv
// System register node on the star: ID, free-running CYCLE counter, CTRL, sticky STATUS
// and four privilege-gated SCRATCH registers, each access answered exactly one cycle later.
module sys_reg_node #(
  parameter logic [63:0] ID_VALUE       = 64'h0000_0000_0000_0000,
  parameter logic [1:0]  SCRATCH_PLEVEL = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [2:0]  rd_regnum,
  input  logic [1:0]  rd_plevel,
  output logic        rd_valid,
  output logic [63:0] rd_val,
  output logic        rd_fault,
  input  logic        wr_en,
  input  logic [2:0]  wr_regnum,
  input  logic [1:0]  wr_plevel,
  input  logic [63:0] wr_val,
  output logic        wr_ack,
  output logic        wr_fault,
  output logic [63:0] ctrl_out
);

  localparam logic [2:0] REG_ID     = 3'd0;
  localparam logic [2:0] REG_CYCLE  = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [1:0] PLEVEL_MAX = 2'd3;

  logic [63:0] cycle_q;
  logic [63:0] ctrl_q;
  logic [1:0]  status_q;
  logic [63:0] scratch_q [4];

  logic        rd_allowed;
  logic        wr_allowed;
  logic        wr_go;
  logic [63:0] rd_data;
  logic [63:0] cycle_next;
  logic [1:0]  status_set;
  logic [1:0]  status_clr;
  logic [1:0]  status_next;

  assign rd_allowed = ~rd_regnum[2] | (rd_plevel >= SCRATCH_PLEVEL);

  always_comb begin
    wr_allowed = 1'b0;
    if (wr_regnum == REG_ID)
      wr_allowed = 1'b0;
    else if (!wr_regnum[2])
      wr_allowed = (wr_plevel == PLEVEL_MAX);
    else
      wr_allowed = (wr_plevel >= SCRATCH_PLEVEL);
  end

  assign wr_go = wr_en & wr_allowed;

  // Read mux sees only pre-edge state, so a same-cycle write is never forwarded.
  always_comb begin
    rd_data = '0;
    case (rd_regnum)
      REG_ID:     rd_data = ID_VALUE;
      REG_CYCLE:  rd_data = cycle_q;
      REG_CTRL:   rd_data = ctrl_q;
      REG_STATUS: rd_data = {62'd0, status_q};
      default:    rd_data = scratch_q[rd_regnum[1:0]];
    endcase
  end

  always_comb begin
    cycle_next = cycle_q;
    if (wr_go && wr_regnum == REG_CYCLE)
      cycle_next = wr_val;
    else if (ctrl_q[0])
      cycle_next = cycle_q + 64'd1;
  end

  // Set wins over write-1-to-clear when both hit the same bit in one cycle.
  always_comb begin
    status_set  = {wr_en & ~wr_allowed, rd_en & ~rd_allowed};
    status_clr  = (wr_go && wr_regnum == REG_STATUS) ? wr_val[1:0] : 2'b00;
    status_next = (status_q & ~status_clr) | status_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_val   <= '0;
      rd_fault <= 1'b0;
      wr_ack   <= 1'b0;
      wr_fault <= 1'b0;
      cycle_q  <= '0;
      ctrl_q   <= 64'h1;
      status_q <= 2'b00;
      for (int i = 0; i < 4; i++)
        scratch_q[i] <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_fault <= rd_en & ~rd_allowed;
      rd_val   <= (rd_en && rd_allowed) ? rd_data : '0;
      wr_ack   <= wr_en;
      wr_fault <= wr_en & ~wr_allowed;
      cycle_q  <= cycle_next;
      status_q <= status_next;
      if (wr_go && wr_regnum == REG_CTRL)
        ctrl_q <= wr_val;
      if (wr_go && wr_regnum[2])
        scratch_q[wr_regnum[1:0]] <= wr_val;
    end
  end

  assign ctrl_out = ctrl_q;

endmodule
